mul_add_iter_stage: RTL and testbench
=====================================

MUL_ADD_ITER_STAGE -- requirements
Module: mul_add_iter_stage

Interface
REQ-001: The block SHALL have one parameter, BITS_PER_CYCLE (default 2): the multiplier-B bits consumed per iteration; the only legal values are 1, 2, 3, 4, 6, 8, 12 and 24 (divisors of 24).
REQ-002: clock  input  1  sole clock; all state updates on the rising edge.
REQ-003: reset  input  1  synchronous, active-high reset.
REQ-004: io_in_valid  input  1  the operand set on the io_in_* ports is valid.
REQ-005: io_in_ready  output  1  the stage accepts an operand set this cycle.
REQ-006: io_in_mulAddA  input  24  unsigned significand multiplicand.
REQ-007: io_in_mulAddB  input  24  unsigned significand multiplier.
REQ-008: io_in_mulAddC  input  48  unsigned aligned addend.
REQ-009: io_in_toPostMul  input  54  packed pre-multiply bundle, carried through unchanged; bit order from MSB down: isSigNaNAny, isNaNAOrB, isInfA, isZeroA, isInfB, isZeroB, signProd, isNaNC, isInfC, isZeroC, sExpSum[9:0], doSubMags, CIsDominant, CDom_CAlignDist[4:0], highAlignedSigC[25:0], bit0AlignedSigC.
REQ-010: io_in_roundingMode  input  3  carried through unchanged.
REQ-011: io_kill  input  1  synchronous abort of the operation in flight.
REQ-012: io_out_valid  output  1  the result is valid.
REQ-013: io_out_ready  input  1  the downstream post-multiply stage accepts the result.
REQ-014: io_out_mulAddResult  output  49  A*B+C, feeding the post-multiply stage's mulAddResult input.
REQ-015: io_out_toPostMul  output  54  captured copy of io_in_toPostMul.
REQ-016: io_out_roundingMode  output  3  captured copy of io_in_roundingMode.
REQ-017: io_busy  output  1  the state is not IDLE.

Function
REQ-018: The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-019: io_in_ready = ~io_kill & (IDLE | (DONE & io_out_ready)).
REQ-020: io_out_valid = DONE & ~io_kill.
REQ-021: Accept (io_in_valid & io_in_ready): A, B, toPostMul and roundingMode are registered; acc <= {1'b0, C}; cnt <= 0; next state is BUSY.
REQ-022: BUSY, each cycle: acc <= acc + ((A * B[cnt*BPC +: BPC]) << (cnt*BPC)); cnt <= cnt+1.
- All arithmetic is unsigned, 49-bit, with no overflow (the maximum sum is below 2^49).
REQ-023: BUSY exits to DONE after the iteration with cnt == 24/BPC-1.
REQ-024: Latency: an operand set accepted at edge T yields io_out_valid high from edge T+24/BPC+1 (T+13 at the default).
REQ-025: DONE with io_out_ready & ~io_kill completes the transfer.
- If io_in_valid is also high, the new operand set is accepted in the same cycle and the next state is BUSY.
- Otherwise the next state is IDLE.
REQ-026: DONE with io_out_ready low: all io_out_* ports SHALL hold stable and the state stays DONE.
REQ-027: io_kill in BUSY or DONE: the next state is IDLE, with no transfer and no acceptance that cycle.
- io_kill in IDLE has no effect other than forcing io_in_ready low.
REQ-028: io_in_* ports are ignored whenever io_in_ready is low.
REQ-029: io_out_mulAddResult equals acc.
- It is defined only while io_out_valid is high.
- It SHALL NOT change while io_out_valid is high and io_out_ready is low.
REQ-030: Throughput SHALL be one operation per 24/BPC+1 cycles under continuous valid/ready.

Reset
REQ-031: While reset is high, the next state is IDLE.
- acc, cnt, A, B and the carried bundles are cleared to 0.
- io_out_valid is 0 and io_busy is 0.
- io_in_ready follows REQ-019 (1 when io_kill is low).
REQ-032: Reset asserted mid-operation discards the operation; no io_out_valid pulse is produced for it.
REQ-033: Reset has priority over io_kill and over acceptance.

Verification
REQ-034: A=0x800000, B=0x800000, C=0, accepted at cycle 0 -> io_out_valid at cycle 13, result 49'h0_4000_0000_0000.
REQ-035: A=B=0xFFFFFF, C=0xFFFF_FFFF_FFFF -> result 49'h1_FFFF_FE00_0000, with no truncation.
REQ-036: io_in_toPostMul=54'h15555555555555, roundingMode=3'h4, io_out_ready held low for 5 cycles after valid ->
- outputs echoed and stable for all 5 cycles, io_in_ready=0;
- then io_out_ready=1 with io_in_valid=1 -> transfer plus new accept in the same cycle, and io_out_valid low the next cycle.
REQ-037: io_kill pulsed on the 5th BUSY cycle -> IDLE on the next cycle, io_in_ready=1, io_busy=0, and no io_out_valid for that operation.
REQ-038: reset pulsed on the 7th BUSY cycle -> io_out_valid=0 and io_in_ready=1 the following cycle; a fresh operation then completes with a correct result 13 cycles after its accept.
REQ-039: Randomized A, B, C with random io_out_ready backpressure, at BITS_PER_CYCLE = 1, 2 and 4 ->
- every result equals a reference A*B+C;
- latency equals 24/BPC+1.

Source files
------------

// File: rtl/mul_add_iter_stage.sv
// Iterative significand multiply-add stage: computes A*B+C over 24/BPC
// cycles, then holds the 49-bit result for the post-multiply stage.
module mul_add_iter_stage #(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [23:0] io_in_mulAddA,
  input  logic [23:0] io_in_mulAddB,
  input  logic [47:0] io_in_mulAddC,
  input  logic [53:0] io_in_toPostMul,
  input  logic [2:0]  io_in_roundingMode,
  input  logic        io_kill,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [48:0] io_out_mulAddResult,
  output logic [53:0] io_out_toPostMul,
  output logic [2:0]  io_out_roundingMode,
  output logic        io_busy
);

  localparam int BPC = BITS_PER_CYCLE;
  localparam int N   = 24 / BPC;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [23:0]     a_q;
  logic [23:0]     b_q;
  logic [48:0]     acc;
  logic [CW-1:0]   cnt;
  logic [53:0]     tpm_q;
  logic [2:0]      rm_q;

  logic [4:0]      sh;
  logic [BPC-1:0]  b_slice;
  logic [48:0]     partial;
  logic            accept;
  logic            last;

  // Partial product of A with the current B digit, placed at its weight.
  always_comb begin
    sh      = 5'(int'(cnt) * BPC);
    b_slice = BPC'(b_q >> sh);
    partial = (49'(a_q) * 49'(b_slice)) << sh;
  end

  assign last = (cnt == CW'(N - 1));

  assign io_in_ready = ~io_kill &
    ((state == IDLE) | ((state == DONE) & io_out_ready));
  assign io_out_valid = (state == DONE) & ~io_kill;
  assign io_busy      = (state != IDLE);
  assign accept       = io_in_valid & io_in_ready;

  assign io_out_mulAddResult = acc;
  assign io_out_toPostMul    = tpm_q;
  assign io_out_roundingMode = rm_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      cnt   <= '0;
      tpm_q <= '0;
      rm_q  <= '0;
    end else if (accept) begin
      state <= BUSY;
      a_q   <= io_in_mulAddA;
      b_q   <= io_in_mulAddB;
      acc   <= {1'b0, io_in_mulAddC};
      cnt   <= '0;
      tpm_q <= io_in_toPostMul;
      rm_q  <= io_in_roundingMode;
    end else if (io_kill) begin
      state <= IDLE;
    end else begin
      case (state)
        BUSY: begin
          acc <= acc + partial;
          cnt <= cnt + 1'b1;
          if (last) state <= DONE;
        end
        DONE: begin
          if (io_out_ready) state <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_add_iter_stage.sv
// Bench for mul_add_iter_stage: directed cases at BPC=2 plus randomized
// runs with backpressure at BPC=1,2,4 against an arithmetic reference.
module tb_mul_add_iter_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid [3];
  logic        in_ready [3];
  logic [23:0] a        [3];
  logic [23:0] b        [3];
  logic [47:0] c        [3];
  logic [53:0] tpm      [3];
  logic [2:0]  rm       [3];
  logic        kill     [3];
  logic        out_valid[3];
  logic        out_ready[3];
  logic [48:0] res      [3];
  logic [53:0] otpm     [3];
  logic [2:0]  orm      [3];
  logic        busy     [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int P = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    mul_add_iter_stage #(.BITS_PER_CYCLE(P)) u_dut (
      .clock              (clk),
      .reset              (rst),
      .io_in_valid        (in_valid[g]),
      .io_in_ready        (in_ready[g]),
      .io_in_mulAddA      (a[g]),
      .io_in_mulAddB      (b[g]),
      .io_in_mulAddC      (c[g]),
      .io_in_toPostMul    (tpm[g]),
      .io_in_roundingMode (rm[g]),
      .io_kill            (kill[g]),
      .io_out_valid       (out_valid[g]),
      .io_out_ready       (out_ready[g]),
      .io_out_mulAddResult(res[g]),
      .io_out_toPostMul   (otpm[g]),
      .io_out_roundingMode(orm[g]),
      .io_busy            (busy[g])
    );
  end

  typedef struct {
    logic [48:0] r;
    logic [53:0] t;
    logic [2:0]  m;
    int          ac;
  } op_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [48:0] ref_mac(input logic [23:0] x,
      input logic [23:0] y, input logic [47:0] z);
    return 49'(x) * 49'(y) + 49'(z);
  endfunction

  // Present an operand set and return in the cycle it is accepted.
  task automatic op_accept(input int k, input logic [23:0] x,
      input logic [23:0] y, input logic [47:0] z,
      input logic [53:0] t, input logic [2:0] m);
    int i;
    @(negedge clk);
    in_valid[k] = 1'b1;
    a[k] = x; b[k] = y; c[k] = z; tpm[k] = t; rm[k] = m;
    #1;
    for (i = 0; i < 40 && !in_ready[k]; i++) begin
      @(negedge clk);
      #1;
    end
    if (i == 40) chk("accept_timeout", 0, 1);
  endtask

  // Cycles from the accepting cycle until out_valid is seen.
  task automatic wait_valid(input int k, output int lat);
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      in_valid[k] = 1'b0;
      #1;
      if (out_valid[k]) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) chk("valid_timeout", 0, 1);
  endtask

  task automatic rand_run(input int k, input int nops);
    int  n;
    int  cyc;
    int  done;
    bit  ev;
    op_t q[$];
    op_t o;
    n = (k == 0) ? 24 : (k == 1) ? 12 : 6;
    cyc = 0;
    done = 0;
    while (done < nops && cyc < 4000) begin
      @(negedge clk);
      out_ready[k] = ($urandom_range(0, 3) != 0);
      in_valid[k]  = ($urandom_range(0, 3) != 0);
      a[k]   = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : 24'($urandom);
      b[k]   = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : 24'($urandom);
      c[k]   = 48'({$urandom, $urandom});
      tpm[k] = 54'({$urandom, $urandom});
      rm[k]  = 3'($urandom);
      #1;
      ev = q.size() != 0 && (cyc - q[0].ac) >= n + 1;
      chk("out_valid", out_valid[k], ev);
      chk("in_ready", in_ready[k],
          q.size() == 0 || (ev && out_ready[k]));
      if (ev && out_valid[k]) begin
        chk("rand_result", res[k], q[0].r);
        chk("rand_tpm", otpm[k], q[0].t);
        chk("rand_rm", orm[k], q[0].m);
      end
      if (ev && out_ready[k]) begin
        void'(q.pop_front());
        done++;
      end
      if (in_valid[k] && in_ready[k]) begin
        o.r  = ref_mac(a[k], b[k], c[k]);
        o.t  = tpm[k];
        o.m  = rm[k];
        o.ac = cyc;
        q.push_back(o);
      end
      cyc++;
    end
    if (done < nops) chk("rand_timeout", done, nops);
    @(negedge clk);
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    repeat (n + 3) @(negedge clk);
  endtask

  initial begin
    int lat;
    bit seen;
    logic [23:0] x;
    logic [23:0] y;
    logic [47:0] z;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; kill[k] = 1'b0; out_ready[k] = 1'b1;
      a[k] = '0; b[k] = '0; c[k] = '0; tpm[k] = '0; rm[k] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid[1], 0);
    chk("rst_busy", busy[1], 0);
    chk("rst_in_ready", in_ready[1], 1);
    chk("rst_result", res[1], 0);
    chk("rst_tpm", otpm[1], 0);
    @(negedge clk);
    rst = 1'b0;

    // 2^23 * 2^23
    op_accept(1, 24'h800000, 24'h800000, 48'h0, 54'h0, 3'h0);
    wait_valid(1, lat);
    chk("pow_latency", lat, 13);
    chk("pow_result", res[1], 49'h0_4000_0000_0000);

    // All-ones operands: carry into bit 48
    op_accept(1, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFF_FFFF_FFFF, 54'h0, 3'h0);
    wait_valid(1, lat);
    chk("max_latency", lat, 13);
    chk("max_result", res[1], 49'h1_FFFF_FE00_0000);

    // Backpressure hold, then transfer with same-cycle accept
    @(negedge clk);
    out_ready[1] = 1'b0;
    op_accept(1, 24'h123456, 24'hABCDEF, 48'h1111_2222_3333,
              54'h15555555555555, 3'h4);
    wait_valid(1, lat);
    chk("bp_latency", lat, 13);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid[1], 1);
      chk("bp_in_ready", in_ready[1], 0);
      chk("bp_result", res[1],
          ref_mac(24'h123456, 24'hABCDEF, 48'h1111_2222_3333));
      chk("bp_tpm", otpm[1], 54'h15555555555555);
      chk("bp_rm", orm[1], 3'h4);
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    out_ready[1] = 1'b1;
    in_valid[1]  = 1'b1;
    a[1] = 24'h00ABCD; b[1] = 24'h0F0F0F; c[1] = 48'h5;
    tpm[1] = 54'h2A; rm[1] = 3'h1;
    #1;
    chk("b2b_in_ready", in_ready[1], 1);
    chk("b2b_out_valid", out_valid[1], 1);
    wait_valid(1, lat);
    chk("b2b_latency", lat, 13);
    chk("b2b_result", res[1], ref_mac(24'h00ABCD, 24'h0F0F0F, 48'h5));
    chk("b2b_tpm", otpm[1], 54'h2A);

    // Kill on the 5th busy cycle
    op_accept(1, 24'h777777, 24'h333333, 48'h9, 54'h0, 3'h0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      in_valid[1] = 1'b0;
    end
    @(negedge clk);
    kill[1] = 1'b1;
    #1;
    chk("kill_in_ready", in_ready[1], 0);
    @(negedge clk);
    kill[1] = 1'b0;
    #1;
    chk("kill_busy", busy[1], 0);
    chk("kill_in_ready_after", in_ready[1], 1);
    chk("kill_out_valid", out_valid[1], 0);
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      #1;
      seen |= out_valid[1];
    end
    chk("kill_no_valid", seen, 0);

    // Reset on the 7th busy cycle
    op_accept(1, 24'h654321, 24'h222222, 48'h1, 54'h3, 3'h2);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      in_valid[1] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid[1], 0);
    chk("mrst_in_ready", in_ready[1], 1);
    chk("mrst_busy", busy[1], 0);
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      #1;
      seen |= out_valid[1];
    end
    chk("mrst_no_valid", seen, 0);
    x = 24'($urandom);
    y = 24'($urandom);
    z = 48'({$urandom, $urandom});
    op_accept(1, x, y, z, 54'h0, 3'h0);
    wait_valid(1, lat);
    chk("mrst_latency", lat, 13);
    chk("mrst_result", res[1], ref_mac(x, y, z));

    for (int k = 0; k < 3; k++) rand_run(k, 25);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
